// File: rtl/genius_control.sv
// rtl/genius_control.sv - Genius game control FSM with ENTER key edge detection; optional macro GENIUS_KEY_SYNC_EN adds a two-flop key synchronizer
module genius_control (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic [3:0] KEY,
   input  logic       end_FPGA,
   input  logic       end_User,
   input  logic       end_time,
   input  logic       win,
   input  logic       match,
   output logic       R1,
   output logic       R2,
   output logic       E1,
   output logic       E2,
   output logic       E3,
   output logic       E4,
   output logic       SEL,
   output logic       win_o,
   output logic [2:0] state_o
);

   localparam logic [2:0] ST_INIT   = 3'd0;
   localparam logic [2:0] ST_SETUP  = 3'd1;
   localparam logic [2:0] ST_FPGA   = 3'd2;
   localparam logic [2:0] ST_USER   = 3'd3;
   localparam logic [2:0] ST_CHECK  = 3'd4;
   localparam logic [2:0] ST_NEXT   = 3'd5;
   localparam logic [2:0] ST_RESULT = 3'd6;

   logic [2:0] state_q, state_d;
   logic       win_q, win_d;
   logic       enter_pulse;

   // Only ENTER (KEY[0]) is used; the other keys are deliberately left dangling.
   logic       unused_keys;
   assign unused_keys = ^KEY[3:1];

   // key_valid_q blocks the edge detector until every history flop holds a
   // real post-reset sample, so a key held across reset release never pulses.
   logic       key_valid_q;

`ifdef GENIUS_KEY_SYNC_EN
   logic       key_s1_q, key_s2_q, key_prev_q;
   logic [1:0] fill_q;

   // Two-flop synchronizer followed by one history flop for falling-edge detection.
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         key_s1_q    <= 1'b1;
         key_s2_q    <= 1'b1;
         key_prev_q  <= 1'b1;
         fill_q      <= 2'd0;
         key_valid_q <= 1'b0;
      end else begin
         key_s1_q    <= KEY[0];
         key_s2_q    <= key_s1_q;
         key_prev_q  <= key_s2_q;
         if (fill_q != 2'd2) begin
            fill_q <= fill_q + 2'd1;
         end
         key_valid_q <= (fill_q == 2'd2);
      end
   end

   assign enter_pulse = key_valid_q & key_prev_q & ~key_s2_q;
`else
   logic       key_q;

   // Single history flop sampling the raw key for falling-edge detection.
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         key_q       <= 1'b1;
         key_valid_q <= 1'b0;
      end else begin
         key_q       <= KEY[0];
         key_valid_q <= 1'b1;
      end
   end

   assign enter_pulse = key_valid_q & key_q & ~KEY[0];
`endif

   // Next-state and win-flag logic; status inputs only matter in the state that consumes them.
   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      case (state_q)
         ST_INIT: begin
            win_d   = 1'b0;
            state_d = ST_SETUP;
         end
         ST_SETUP: begin
            if (enter_pulse) state_d = ST_FPGA;
         end
         ST_FPGA: begin
            if (end_FPGA) state_d = ST_USER;
         end
         ST_USER: begin
            if (end_time)      state_d = ST_RESULT;
            else if (end_User) state_d = ST_CHECK;
         end
         ST_CHECK: begin
            if (!match) begin
               state_d = ST_RESULT;
            end else if (win) begin
               state_d = ST_RESULT;
               win_d   = 1'b1;
            end else begin
               state_d = ST_NEXT;
            end
         end
         ST_NEXT: begin
            state_d = ST_FPGA;
         end
         ST_RESULT: begin
            if (enter_pulse) state_d = ST_INIT;
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   // State and win-flag registers.
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         state_q <= ST_INIT;
         win_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
      end
   end

   // Moore control decode from the state register alone.
   always_comb begin
      R1  = 1'b0;
      R2  = 1'b0;
      E1  = 1'b0;
      E2  = 1'b0;
      E3  = 1'b0;
      E4  = 1'b0;
      SEL = 1'b0;
      case (state_q)
         ST_INIT: begin
            R1 = 1'b1;
            R2 = 1'b1;
         end
         ST_SETUP:  E1  = 1'b1;
         ST_FPGA:   E3  = 1'b1;
         ST_USER:   E2  = 1'b1;
         ST_NEXT: begin
            E4 = 1'b1;
            R2 = 1'b1;
         end
         ST_RESULT: SEL = 1'b1;
         default: ;
      endcase
   end

   assign win_o   = win_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_genius_control.sv
// tb/tb_genius_control.sv - randomized self-checking bench for genius_control against a game-rule model
module tb_genius_control;

   logic       CLOCK_50 = 1'b0;
   logic       reset    = 1'b0;
   logic [3:0] KEY      = 4'hF;
   logic       end_FPGA = 1'b0;
   logic       end_User = 1'b0;
   logic       end_time = 1'b0;
   logic       win      = 1'b0;
   logic       match    = 1'b0;
   logic       R1, R2, E1, E2, E3, E4, SEL, win_o;
   logic [2:0] state_o;

   genius_control dut (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .KEY      (KEY),
      .end_FPGA (end_FPGA),
      .end_User (end_User),
      .end_time (end_time),
      .win      (win),
      .match    (match),
      .R1       (R1),
      .R2       (R2),
      .E1       (E1),
      .E2       (E2),
      .E3       (E3),
      .E4       (E4),
      .SEL      (SEL),
      .win_o    (win_o),
      .state_o  (state_o)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

`ifdef GENIUS_KEY_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   int   checks = 0;
   int   errors = 0;
   int   m_state;
   logic m_win;
   int   cyc;
   logic key_hist[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Control word {R1,R2,E1,E2,E3,E4,SEL} the game phase should present.
   function automatic logic [6:0] exp_ctrl(input int s);
      case (s)
         0:       return 7'b1100000;
         1:       return 7'b0010000;
         2:       return 7'b0000100;
         3:       return 7'b0001000;
         5:       return 7'b0100010;
         6:       return 7'b0000001;
         default: return 7'b0000000;
      endcase
   endfunction

   // An ENTER is seen at edge c when the key fell LAT-1 cycles earlier and
   // both samples were taken after reset release.
   function automatic logic enter_at(input int c);
      if (c - LAT < 1) return 1'b0;
      return key_hist[c - LAT] && !key_hist[c - LAT + 1];
   endfunction

   task automatic compare_outputs();
      check("state", 32'(state_o), 32'(m_state));
      check("ctrl", 32'({R1, R2, E1, E2, E3, E4, SEL}), 32'(exp_ctrl(m_state)));
      check("win", 32'(win_o), 32'(m_win));
   endtask

   // One clock: capture inputs, advance the model by the game rules, compare.
   task automatic step();
      logic k, ef, eu, et, w, mt, ent;
      k  = KEY[0];
      ef = end_FPGA;
      eu = end_User;
      et = end_time;
      w  = win;
      mt = match;
      @(posedge CLOCK_50);
      cyc++;
      key_hist.push_back(k);
      ent = enter_at(cyc);
      case (m_state)
         0: begin m_win = 1'b0; m_state = 1; end
         1: if (ent) m_state = 2;
         2: if (ef) m_state = 3;
         3: if (et) m_state = 6; else if (eu) m_state = 4;
         4: begin
            if (!mt) m_state = 6;
            else if (w) begin m_state = 6; m_win = 1'b1; end
            else m_state = 5;
         end
         5: m_state = 2;
         6: if (ent) m_state = 0;
         default: m_state = 0;
      endcase
      #1;
      compare_outputs();
   endtask

   // Asynchronous reset mid-cycle with a chosen key level, held for two clocks.
   task automatic do_reset(input logic key_low);
      #3;
      reset  = 1'b0;
      KEY[0] = !key_low;
      #1;
      m_state = 0;
      m_win   = 1'b0;
      compare_outputs();
      repeat (2) @(posedge CLOCK_50);
      #1;
      compare_outputs();
      reset = 1'b1;
      cyc   = 0;
      key_hist.delete();
      key_hist.push_back(1'b1);
   endtask

   task automatic clear_status();
      end_FPGA = 1'b0;
      end_User = 1'b0;
      end_time = 1'b0;
      win      = 1'b0;
      match    = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      cyc = 0;
      m_state = 0;
      m_win   = 1'b0;
      key_hist.push_back(1'b1);
      @(posedge CLOCK_50);
      #1;
      do_reset(1'b1);

      // Key held low across release: INIT, then SETUP, no spurious ENTER.
      repeat (8) step();
      check("held_key_setup", 32'(state_o), 32'd1);

      // Release, press: measure latency from the falling edge.
      KEY[0] = 1'b1;
      repeat (3) step();
      KEY[0] = 1'b0;
      n = 0;
      while (state_o != 3'd2 && n < 10) begin
         step();
         n++;
      end
      check("enter_latency", 32'(n), 32'(LAT));

      // Key still held for 10 cycles in FPGA: no state change.
      repeat (10) step();
      check("held_key_fpga", 32'(state_o), 32'd2);

      // Directed round: win path then ENTER back to INIT.
      end_FPGA = 1'b1; step(); clear_status();
      end_User = 1'b1; step(); clear_status();
      match = 1'b1; win = 1'b1; step(); clear_status();
      check("won_result", 32'({state_o, win_o}), 32'({3'd6, 1'b1}));
      KEY[0] = 1'b1; step();
      KEY[0] = 1'b0;
      repeat (LAT + 1) step();
      KEY[0] = 1'b1;

      // Randomized play with occasional mid-game resets.
      for (int i = 0; i < 4000; i++) begin
         end_FPGA = ($urandom_range(0, 3) == 0);
         end_User = ($urandom_range(0, 3) == 0);
         end_time = ($urandom_range(0, 7) == 0);
         match    = ($urandom_range(0, 3) != 0);
         win      = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 3) == 0) KEY[0] = ~KEY[0];
         KEY[3:1] = 3'($urandom);
         if ($urandom_range(0, 599) == 0) begin
            do_reset(1'($urandom));
         end
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
